// File: rtl/perf_pkg.sv
// perf_pkg
//   Shared definitions for the performance monitor slice:
//   - perfState_e : monitor FSM state encoding (RUN / DUMP / HALTED)
//   - EV_*        : event-channel positions inside event_vec
//   - idxWidth()  : width of an index covering all event counters plus
//                   the cycle counter
package perf_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DUMP   = 2'b01,
    ST_HALTED = 2'b10
  } perfState_e;

  localparam int EV_RETIRE     = 0;
  localparam int EV_ICACHE_REQ = 1;
  localparam int EV_ICACHE_HIT = 2;
  localparam int EV_DCACHE_REQ = 3;
  localparam int EV_DCACHE_HIT = 4;
  localparam int EV_STALL      = 5;

  localparam int NUM_EVENTS_DEF = 6;

  // Counter index space is 0..numEvents (the extra slot is the cycle counter).
  function automatic int idxWidth(input int numEvents);
    return $clog2(numEvents + 1);
  endfunction

endpackage

// File: rtl/perf_monitor_if.sv
// perf_monitor_if
//   Bundles the random-access read port and the dump stream port of the
//   performance monitor.
//   Read port : rd_req/rd_idx (request), rd_valid/rd_data/rd_err (response)
//   Dump port : dump_valid/dump_idx/dump_data (beat), dump_ready (sink)
//   master : the agent issuing reads and sinking dump beats
//   slave  : the monitor itself
interface perf_monitor_if
  import perf_pkg::*;
#(
  parameter int NUM_EVENTS = NUM_EVENTS_DEF,
  parameter int CNT_W      = 32
);

  localparam int IDX_W = idxWidth(NUM_EVENTS);

  logic             rd_req;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic             rd_err;
  logic             dump_valid;
  logic [IDX_W-1:0] dump_idx;
  logic [CNT_W-1:0] dump_data;
  logic             dump_ready;

  modport master (
    output rd_req, rd_idx, dump_ready,
    input  rd_valid, rd_data, rd_err, dump_valid, dump_idx, dump_data
  );

  modport slave (
    input  rd_req, rd_idx, dump_ready,
    output rd_valid, rd_data, rd_err, dump_valid, dump_idx, dump_data
  );

endinterface

// File: rtl/perf_ctr.sv
// perf_ctr
//   Saturating up-counter with enable, synchronous clear and a sticky
//   saturation flag.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   clr   : synchronous clear of count and flag
//   en    : count one event this cycle
//   count : current value
//   sat   : set when an increment is attempted at the maximum value
module perf_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MAX_VAL = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_r;
  logic             sat_r;

  // Counter state: hold at the maximum and latch the flag instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
      sat_r   <= 1'b0;
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
      sat_r   <= 1'b0;
    end else if (en) begin
      if (count_r == MAX_VAL) begin
        sat_r <= 1'b1;
      end else begin
        count_r <= count_r + CNT_W'(1);
      end
    end
  end

  assign count = count_r;
  assign sat   = sat_r;

endmodule

// File: rtl/perf_monitor.sv
// perf_monitor
//   Processor performance monitor: NUM_EVENTS event counters plus a cycle
//   counter. On halt the counters freeze and are streamed out as dump
//   beats (index 0..NUM_EVENTS); a random-access read port works in every
//   state.
//   clk       : clock
//   rst_n     : synchronous active-low reset
//   event_vec : per-channel event pulses
//   halt      : freeze counters and start the dump
//   clear     : synchronous soft clear, returns to RUN
//   bus       : read port and dump stream (slave side)
//   frozen    : counters are frozen (DUMP or HALTED)
//   ovf       : sticky saturation flags, MSB is the cycle counter
module perf_monitor
  import perf_pkg::*;
#(
  parameter int NUM_EVENTS = NUM_EVENTS_DEF,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_EVENTS-1:0] event_vec,
  input  logic                  halt,
  input  logic                  clear,
  perf_monitor_if.slave         bus,
  output logic                  frozen,
  output logic [NUM_EVENTS:0]   ovf
);

  localparam int               IDX_W    = idxWidth(NUM_EVENTS);
  localparam int               NUM_CTR  = NUM_EVENTS + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EVENTS);

  perfState_e       state_r;
  perfState_e       nextState_s;
  logic             frozen_r;

  logic [CNT_W-1:0] cnt_s [NUM_CTR];
  logic [NUM_CTR-1:0] ctrEn_s;

  logic             rdValid_r;
  logic [CNT_W-1:0] rdData_r;
  logic             rdErr_r;
  logic [CNT_W-1:0] rdSel_s;
  logic             rdOob_s;

  logic             dumpValid_r;
  logic [IDX_W-1:0] dumpIdx_r;
  logic [CNT_W-1:0] dumpData_r;
  logic             dumpValidNxt_s;
  logic [IDX_W-1:0] dumpIdxNxt_s;
  logic [CNT_W-1:0] dumpSel_s;
  logic [CNT_W-1:0] dumpDataNxt_s;

  // Counter enables: only in RUN and never in a clear cycle; the cycle
  // counter (top slot) ticks unconditionally while running.
  always_comb begin
    ctrEn_s = {NUM_CTR{1'b0}};
    if ((state_r == ST_RUN) && !clear) begin
      ctrEn_s = {1'b1, event_vec};
    end else begin
      ctrEn_s = {NUM_CTR{1'b0}};
    end
  end

  for (genvar g = 0; g < NUM_CTR; g++) begin : gCtr
    perf_ctr #(.CNT_W(CNT_W)) uCtr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .en    (ctrEn_s[g]),
      .count (cnt_s[g]),
      .sat   (ovf[g])
    );
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_RUN;
      frozen_r <= 1'b0;
    end else begin
      state_r  <= nextState_s;
      frozen_r <= (nextState_s != ST_RUN);
    end
  end

  // FSM next state: clear overrides everything, halt is honoured only in RUN.
  always_comb begin
    nextState_s = state_r;
    if (clear) begin
      nextState_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN:    nextState_s = halt ? ST_DUMP : ST_RUN;
        ST_DUMP:   nextState_s = (dumpValid_r && bus.dump_ready && (dumpIdx_r == LAST_IDX))
                                 ? ST_HALTED : ST_DUMP;
        ST_HALTED: nextState_s = ST_HALTED;
        default:   nextState_s = ST_RUN;
      endcase
    end
  end

  // Read mux: out-of-range indices select nothing and are flagged.
  always_comb begin
    rdSel_s = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_CTR; i++) begin
      rdSel_s = (bus.rd_idx == IDX_W'(i)) ? cnt_s[i] : rdSel_s;
    end
    rdOob_s = (bus.rd_idx > LAST_IDX);
  end

  // Read response: samples the pre-increment (and pre-clear) counter value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdValid_r <= 1'b0;
      rdData_r  <= {CNT_W{1'b0}};
      rdErr_r   <= 1'b0;
    end else begin
      rdValid_r <= bus.rd_req;
      rdErr_r   <= bus.rd_req && rdOob_s;
      rdData_r  <= (bus.rd_req && !rdOob_s) ? rdSel_s : {CNT_W{1'b0}};
    end
  end

  // Dump sequencing: the first DUMP cycle loads beat 0, later beats advance
  // on acceptance, and accepting the last beat drops valid.
  always_comb begin
    dumpValidNxt_s = dumpValid_r;
    dumpIdxNxt_s   = dumpIdx_r;
    if (state_r == ST_DUMP) begin
      if (!dumpValid_r) begin
        dumpValidNxt_s = 1'b1;
        dumpIdxNxt_s   = {IDX_W{1'b0}};
      end else if (bus.dump_ready) begin
        if (dumpIdx_r == LAST_IDX) begin
          dumpValidNxt_s = 1'b0;
        end else begin
          dumpIdxNxt_s = dumpIdx_r + IDX_W'(1);
        end
      end else begin
        dumpIdxNxt_s = dumpIdx_r;
      end
    end else begin
      dumpValidNxt_s = 1'b0;
    end
  end

  // Dump data mux: counters are frozen in DUMP, so the selected value is stable.
  always_comb begin
    dumpSel_s = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_CTR; i++) begin
      dumpSel_s = (dumpIdxNxt_s == IDX_W'(i)) ? cnt_s[i] : dumpSel_s;
    end
    if (state_r == ST_DUMP) begin
      dumpDataNxt_s = dumpSel_s;
    end else begin
      dumpDataNxt_s = dumpData_r;
    end
  end

  // Dump output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dumpValid_r <= 1'b0;
      dumpIdx_r   <= {IDX_W{1'b0}};
      dumpData_r  <= {CNT_W{1'b0}};
    end else if (clear) begin
      dumpValid_r <= 1'b0;
      dumpIdx_r   <= {IDX_W{1'b0}};
      dumpData_r  <= {CNT_W{1'b0}};
    end else begin
      dumpValid_r <= dumpValidNxt_s;
      dumpIdx_r   <= dumpIdxNxt_s;
      dumpData_r  <= dumpDataNxt_s;
    end
  end

  assign bus.rd_valid   = rdValid_r;
  assign bus.rd_data    = rdData_r;
  assign bus.rd_err     = rdErr_r;
  assign bus.dump_valid = dumpValid_r;
  assign bus.dump_idx   = dumpIdx_r;
  assign bus.dump_data  = dumpData_r;
  assign frozen         = frozen_r;

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 Parameter NUM_EVENTS, default 6, SHALL set the number of event channels (0 retire, 1 icache req, 2 icache hit, 3 dcache req, 4 dcache hit, 5 stall).
REQ-002 Parameter CNT_W, default 32, SHALL set the width of every counter, including the cycle counter.
REQ-003 Derived constant IDX_W = clog2(NUM_EVENTS+1) SHALL set the width of all counter indices.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 event_vec  in  NUM_EVENTS  per-channel event pulse, sampled every clk.
REQ-007 halt  in  1  processor halt, sampled every clk; triggers freeze and dump.
REQ-008 clear  in  1  synchronous soft clear of all counters and state.
REQ-009 rd_req  in  1  random-access read request.
REQ-010 rd_idx  in  IDX_W  read index: 0..NUM_EVENTS-1 events, NUM_EVENTS cycle counter.
REQ-011 rd_valid  out  1  rd_data valid, exactly one cycle after rd_req.
REQ-012 rd_data  out  CNT_W  read result.
REQ-013 rd_err  out  1  asserted with rd_valid when rd_idx > NUM_EVENTS.
REQ-014 dump_valid  out  1  dump beat valid.
REQ-015 dump_idx  out  IDX_W  index of the current dump beat.
REQ-016 dump_data  out  CNT_W  counter value of the current dump beat.
REQ-017 dump_ready  in  1  sink accepts a dump beat when high together with dump_valid.
REQ-018 frozen  out  1  high in DUMP and HALTED.
REQ-019 ovf  out  NUM_EVENTS+1  sticky saturation flags; bit NUM_EVENTS is the cycle counter.

Function
REQ-020 The FSM SHALL have three states: RUN, DUMP and HALTED.
REQ-021 In RUN, each cycle counter i SHALL increment by 1 when event_vec[i]=1, and the cycle counter SHALL increment by 1 unconditionally.
REQ-022 A counter at 2^CNT_W-1 SHALL hold that value on further increments and set its ovf bit, which stays set until clear or reset.
REQ-023 RUN SHALL go to DUMP on halt=1, and events present in the halt cycle (including that cycle's cycle count) SHALL be counted.
REQ-024 In DUMP and HALTED, no counter SHALL change, and event_vec and halt SHALL be ignored.
REQ-025 DUMP SHALL present beats with indices 0..NUM_EVENTS in ascending order, starting the cycle after entry.
REQ-026 A dump beat SHALL advance only on dump_valid & dump_ready; with dump_ready low, dump_idx and dump_data SHALL be held.
REQ-027 Acceptance of beat NUM_EVENTS SHALL move the FSM to HALTED and deassert dump_valid in the next cycle.
REQ-028 HALTED SHALL be left only via clear or reset.
REQ-029 clear=1 in any state SHALL, next cycle, zero all counters and ovf, drop dump_valid and enter RUN.
REQ-030 clear SHALL take priority over simultaneous halt and events; nothing in that cycle is counted.
REQ-031 Reads SHALL be legal in every state, with a latency of 1 cycle.
REQ-032 Reads SHALL return the counter value before that cycle's increment.
REQ-033 An out-of-range read SHALL return rd_data=0 with rd_err=1.
REQ-034 A read in the same cycle as clear SHALL return the pre-clear value.
REQ-035 rd_valid SHALL be low in every cycle not following an rd_req.

Reset
REQ-036 With rst_n=0 at a clk edge, the block SHALL enter RUN with all counters=0, ovf=0, rd_valid=0, rd_data=0, rd_err=0, dump_valid=0, dump_idx=0, dump_data=0 and frozen=0.
REQ-037 Reset during DUMP SHALL abort the dump with no further beats.
REQ-038 All inputs SHALL be ignored while rst_n=0.

Structure
REQ-039 Shared package perf_pkg SHALL hold the FSM state encoding and the event-channel index constants (EV_RETIRE..EV_STALL).
REQ-040 Sub-module perf_ctr (parametrised CNT_W saturating counter with enable, clear and sticky ovf) SHALL be instantiated NUM_EVENTS+1 times.
REQ-041 The FSM, read mux and dump mux SHALL live in perf_monitor.

Verification
REQ-042 Reset, then 10 cycles with event_vec=6'b000001, then halt: the dump SHALL give idx0=11, idx1..5=0 and idx6=11; the retire count includes the halt-cycle event.
REQ-043 With CNT_W=8, event 3 held high for 300 cycles: rd_idx=3 SHALL read 255 and ovf[3]=1.
REQ-044 Halt with dump_ready low for 5 cycles, then high: beat 0 SHALL be held for 5 cycles, then 7 beats on consecutive cycles, then HALTED.
REQ-045 clear and halt asserted in the same cycle with event_vec=all-ones: next cycle state SHALL be RUN, all counters 0, frozen=0.
REQ-046 rd_req with rd_idx=7 (NUM_EVENTS=6): one cycle later rd_valid=1, rd_err=1, rd_data=0.
REQ-047 rst_n=0 asserted after beat 2 of a dump: dump_valid SHALL be 0 from the next cycle, with all counters 0.
